// File: rtl/adc_pkg.sv
// Shared types and default geometry for the ADC ingest path.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2,
    HOLDOFF   = 2'd3
  } sched_state_t;

  localparam int DEF_WORDS_PER_FRAME  = 9;
  localparam int DEF_FIFO_DEPTH_WORDS = 64;

endpackage

// File: rtl/adc_period_ticker.sv
// Free-running down-counter that emits a tick every `period` cycles while run is high.
// A period of 0 ticks every cycle; while not running the counter parks at its reload value.
module adc_period_ticker #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload;

  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick   = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (!run || cnt == '0) cnt <= reload;
    else                       cnt <= cnt - PERIOD_W'(1);
  end

endmodule

// File: rtl/adc_capture_scheduler.sv
// Decides when to pulse the ingest capture start: periodic or one-shot requests,
// gated on ingest idle, drain holdoff and FIFO headroom for a whole frame.
module adc_capture_scheduler
  import adc_pkg::*;
#(
  parameter int WORDS_PER_FRAME  = DEF_WORDS_PER_FRAME,
  parameter int FIFO_DEPTH_WORDS = DEF_FIFO_DEPTH_WORDS,
  parameter int PERIOD_W         = 32,
  parameter int HOLDOFF_CYCLES   = WORDS_PER_FRAME + 2,
  parameter int BUSY_TIMEOUT     = 8,
  parameter int LEVEL_W          = $clog2(FIFO_DEPTH_WORDS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                continuous,
  input  logic [PERIOD_W-1:0] period_cycles,
  input  logic                oneshot_req,
  output logic                start,
  input  logic                capture_busy,
  input  logic [LEVEL_W-1:0]  fifo_level_words,
  output logic [31:0]         frame_count,
  output logic [15:0]         skip_count,
  input  logic                skip_clear,
  output logic                start_timeout_sticky,
  input  logic                timeout_clear,
  output logic                sched_busy
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int LS = LEVEL_W + 1;

  sched_state_t   state;
  logic           pending;
  logic [TW-1:0]  tcnt;
  logic [HW-1:0]  hcnt;
  logic [LS-1:0]  level_sum;
  logic           tick, oneshot_en, req, want, can_start, launch, skip_inc, timeout_hit;

  adc_period_ticker #(.PERIOD_W(PERIOD_W)) u_ticker (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (enable & continuous),
    .period (period_cycles),
    .tick   (tick)
  );

  always_comb begin
    oneshot_en  = oneshot_req & enable;
    req         = tick | oneshot_en;
    // one extra bit so level + frame cannot wrap before the compare
    level_sum   = {1'b0, fifo_level_words} + LS'(WORDS_PER_FRAME);
    can_start   = (level_sum <= LS'(FIFO_DEPTH_WORDS)) && !capture_busy;
    want        = enable && (req || pending);
    launch      = (state == IDLE) && want && can_start;
    timeout_hit = (state == WAIT_RISE) && !capture_busy && (tcnt == TW'(BUSY_TIMEOUT - 1));
    skip_inc    = 1'b0;
    if (state == IDLE) skip_inc = want && !can_start;
    // a one-shot that can park in the empty pending slot is not a skip, even alongside a tick
    else               skip_inc = req && !(oneshot_en && !pending);
  end

  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      start                <= 1'b0;
      pending              <= 1'b0;
      tcnt                 <= '0;
      hcnt                 <= '0;
      frame_count          <= '0;
      skip_count           <= '0;
      start_timeout_sticky <= 1'b0;
    end else begin
      start <= launch;

      // IDLE always consumes the pending request, serviced or skipped
      if (!enable || state == IDLE) pending <= 1'b0;
      else if (oneshot_en)          pending <= 1'b1;

      if (skip_clear)                              skip_count <= {15'b0, skip_inc};
      else if (skip_inc && skip_count != 16'hFFFF) skip_count <= skip_count + 16'd1;

      if (timeout_hit)        start_timeout_sticky <= 1'b1;
      else if (timeout_clear) start_timeout_sticky <= 1'b0;

      case (state)
        IDLE: if (launch) begin
          state <= WAIT_RISE;
          tcnt  <= '0;
        end
        WAIT_RISE: begin
          if (capture_busy) begin
            frame_count <= frame_count + 32'd1;
            state       <= WAIT_FALL;
          end else if (timeout_hit) begin
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_FALL: if (!capture_busy) begin
          state <= HOLDOFF;
          hcnt  <= HW'(HOLDOFF_CYCLES - 1);
        end
        HOLDOFF: begin
          if (hcnt == '0) state <= IDLE;
          else            hcnt  <= hcnt - HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Scoreboard bench: stimulus queues the cycle each start pulse is due, a negedge monitor
// pops and compares; counters and flags are checked at hand-computed cycles.
module tb_adc_capture_scheduler;

  localparam int LEVEL_W = 7;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               enable = 1'b0, continuous = 1'b0, oneshot_req = 1'b0;
  logic               capture_busy = 1'b0, skip_clear = 1'b0, timeout_clear = 1'b0;
  logic [31:0]        period_cycles = '0;
  logic [LEVEL_W-1:0] fifo_level_words = '0;
  logic               start, start_timeout_sticky, sched_busy;
  logic [31:0]        frame_count;
  logic [15:0]        skip_count;

  int cyc = 0, checks = 0, errors = 0, exp_frame = 0;
  int exp_q[$];
  int busy_len = 30, left = 0;
  bit model_on = 1'b0, model_rst = 1'b0;

  adc_capture_scheduler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable               (enable),
    .continuous           (continuous),
    .period_cycles        (period_cycles),
    .oneshot_req          (oneshot_req),
    .start                (start),
    .capture_busy         (capture_busy),
    .fifo_level_words     (fifo_level_words),
    .frame_count          (frame_count),
    .skip_count           (skip_count),
    .skip_clear           (skip_clear),
    .start_timeout_sticky (start_timeout_sticky),
    .timeout_clear        (timeout_clear),
    .sched_busy           (sched_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ingest model: busy goes high the cycle start is seen and stays high busy_len cycles
  initial forever begin
    @(negedge clk);
    if (model_rst)               left = 0;
    else if (model_on && start)  left = busy_len;
    else if (left > 0)           left--;
    capture_busy = (left > 0);
  end

  always @(negedge clk) begin
    if (rst_n && start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL start_unexpected: start at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc != e) begin
          errors++;
          $display("FAIL start_cycle: got cycle %0d expected %0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sched_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sched_busy) begin
      errors++;
      $display("FAIL idle_wait: sched_busy got 1 expected 0 after %0d cycles", n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_frame", frame_count, 0);
    chk("rst_skip", skip_count, 0);
    chk("rst_sticky", start_timeout_sticky, 0);
    chk("rst_sched_busy", sched_busy, 0);

    // periodic, period 100, busy 30: starts exactly 100 apart
    rst_n = 1'b1; period_cycles = 100; continuous = 1'b1; busy_len = 30; model_on = 1'b1;
    @(negedge clk); k = cyc; enable = 1'b1;
    for (int m = 1; m <= 10; m++) exp_q.push_back(k + 100 * m);
    exp_frame += 10;
    wait_until(k + 1050);
    chk("a_frame", frame_count, exp_frame);
    chk("a_skip", skip_count, 0);
    chk("a_idle", sched_busy, 0);
    enable = 1'b0;

    // period 20, busy 20: each sequence swallows the next tick
    period_cycles = 20; busy_len = 20;
    @(negedge clk); k = cyc; enable = 1'b1;
    for (int m = 0; m < 4; m++) exp_q.push_back(k + 20 + 40 * m);
    exp_frame += 4;
    wait_until(k + 150);
    chk("b_skip", skip_count, 3);
    enable = 1'b0;
    wait_until(k + 180);
    chk("b_frame", frame_count, exp_frame);
    chk("b_skip_hold", skip_count, 3);
    chk("b_idle", sched_busy, 0);

    // headroom: 56+9 > 64 skips (with same-cycle clear), 55+9 == 64 starts
    continuous = 1'b0; enable = 1'b1; fifo_level_words = 56; oneshot_req = 1'b1; skip_clear = 1'b1;
    @(negedge clk); oneshot_req = 1'b0; skip_clear = 1'b0;
    chk("c_skip_clear_inc", skip_count, 1);
    chk("c_no_start_busy", sched_busy, 0);
    fifo_level_words = 55; busy_len = 5;
    @(negedge clk); k = cyc; oneshot_req = 1'b1; exp_q.push_back(k + 1); exp_frame++;
    @(negedge clk); oneshot_req = 1'b0;
    wait_idle();
    chk("c_frame", frame_count, exp_frame);

    // busy never rises: timeout after 8 cycles in WAIT_RISE
    model_on = 1'b0;
    @(negedge clk); k = cyc; s = k + 1; oneshot_req = 1'b1; exp_q.push_back(s);
    @(negedge clk); oneshot_req = 1'b0;
    wait_until(s + 7);
    chk("d_sticky_early", start_timeout_sticky, 0);
    chk("d_waiting", sched_busy, 1);
    wait_until(s + 8);
    chk("d_sticky_set", start_timeout_sticky, 1);
    chk("d_back_idle", sched_busy, 0);
    chk("d_frame", frame_count, exp_frame);
    timeout_clear = 1'b1;
    @(negedge clk); timeout_clear = 1'b0;
    chk("d_sticky_clear", start_timeout_sticky, 0);

    // two one-shots in WAIT_FALL: one pends, one skips; pending starts after holdoff
    model_on = 1'b1; busy_len = 10; skip_clear = 1'b1;
    @(negedge clk); skip_clear = 1'b0; k = cyc; s = k + 1; oneshot_req = 1'b1; exp_q.push_back(s);
    @(negedge clk); oneshot_req = 1'b0;
    wait_until(s + 3); oneshot_req = 1'b1;
    @(negedge clk); oneshot_req = 1'b0;
    wait_until(s + 5); oneshot_req = 1'b1;
    @(negedge clk); oneshot_req = 1'b0;
    exp_q.push_back(s + 23); exp_frame += 2;
    wait_until(s + 24);
    chk("e_pending_skip", skip_count, 1);
    wait_idle();
    chk("e_frame", frame_count, exp_frame);

    // tick and one-shot in the same cycle merge into one start
    continuous = 1'b0; period_cycles = 5;
    @(negedge clk); k = cyc; continuous = 1'b1;
    wait_until(k + 4); oneshot_req = 1'b1; exp_q.push_back(k + 5); exp_frame++;
    @(negedge clk); oneshot_req = 1'b0;
    @(negedge clk); continuous = 1'b0;
    wait_idle();
    chk("e2_skip", skip_count, 1);
    chk("e2_frame", frame_count, exp_frame);

    // async reset in WAIT_FALL, then the first tick after release starts
    busy_len = 30; period_cycles = 50;
    @(negedge clk); k = cyc; s = k + 1; oneshot_req = 1'b1; exp_q.push_back(s);
    @(negedge clk); oneshot_req = 1'b0;
    wait_until(s + 5);
    chk("f_pre_busy", sched_busy, 1);
    #2 rst_n = 1'b0; model_rst = 1'b1;
    #1;
    chk("f_rst_start", start, 0);
    chk("f_rst_sched_busy", sched_busy, 0);
    chk("f_rst_frame", frame_count, 0);
    chk("f_rst_skip", skip_count, 0);
    chk("f_rst_sticky", start_timeout_sticky, 0);
    exp_frame = 0; continuous = 1'b1; fifo_level_words = 0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; model_rst = 1'b0; k = cyc; exp_q.push_back(k + 1); exp_frame = 1;
    wait_until(k + 3); enable = 1'b0; continuous = 1'b0;
    wait_idle();
    chk("f_frame", frame_count, exp_frame);
    chk("f_skip", skip_count, 0);

    @(negedge clk);
    chk("pending_starts", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
